// File: rtl/regfile_write_bank_if.sv
// Write-port bundle for regfile_write_bank: write request, bulk-clear request, ack and busy.
// The master drives requests; the slave (the register bank) returns wr_ack and busy.
interface regfile_write_bank_if #(
  parameter int WIDTH = 32
);
  logic             we;
  logic [4:0]       wa;
  logic [WIDTH-1:0] wd;
  logic             clr_req;
  logic             wr_ack;
  logic             busy;

  modport master (
    output we,
    output wa,
    output wd,
    output clr_req,
    input  wr_ack,
    input  busy
  );

  modport slave (
    input  we,
    input  wa,
    input  wd,
    input  clr_req,
    output wr_ack,
    output busy
  );
endinterface

// File: rtl/regfile_write_bank.sv
// 32 x WIDTH register file write side with 1-cycle write latency and a 32-cycle bulk-clear sweep (busy blocks writes).
// Define REGFILE_ZERO_REG_EN to hardwire register 0 to zero (writes to it are still acknowledged).
module regfile_write_bank #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  regfile_write_bank_if.slave wr,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic [WIDTH-1:0] q4,
  output logic [WIDTH-1:0] q5,
  output logic [WIDTH-1:0] q6,
  output logic [WIDTH-1:0] q7,
  output logic [WIDTH-1:0] q8,
  output logic [WIDTH-1:0] q9,
  output logic [WIDTH-1:0] q10,
  output logic [WIDTH-1:0] q11,
  output logic [WIDTH-1:0] q12,
  output logic [WIDTH-1:0] q13,
  output logic [WIDTH-1:0] q14,
  output logic [WIDTH-1:0] q15,
  output logic [WIDTH-1:0] q16,
  output logic [WIDTH-1:0] q17,
  output logic [WIDTH-1:0] q18,
  output logic [WIDTH-1:0] q19,
  output logic [WIDTH-1:0] q20,
  output logic [WIDTH-1:0] q21,
  output logic [WIDTH-1:0] q22,
  output logic [WIDTH-1:0] q23,
  output logic [WIDTH-1:0] q24,
  output logic [WIDTH-1:0] q25,
  output logic [WIDTH-1:0] q26,
  output logic [WIDTH-1:0] q27,
  output logic [WIDTH-1:0] q28,
  output logic [WIDTH-1:0] q29,
  output logic [WIDTH-1:0] q30,
  output logic [WIDTH-1:0] q31
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] CLEAR = 1'b1;

  logic [0:0]            state;
  logic [4:0]            ptr;
  logic                  wr_ack_q;
  logic                  wr_go;
  logic [31:0]           wr_hit;
  logic [31:0]           clr_hit;
  logic [31:0][WIDTH-1:0] regs;

  // A clear request in the same IDLE cycle as a write wins: the write is dropped.
  assign wr_go = (state == IDLE) && wr.we && !wr.clr_req;

  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    if (wr_go) begin
      wr_hit[wr.wa] = 1'b1;
    end
    if (state == CLEAR) begin
      clr_hit[ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= '0;
      wr_ack_q <= 1'b0;
    end else begin
      wr_ack_q <= wr_go;
      case (state)
        IDLE: begin
          if (wr.clr_req) begin
            state <= CLEAR;
            ptr   <= '0;
          end
        end
        CLEAR: begin
          if (ptr == 5'd31) begin
            state <= IDLE;
            ptr   <= '0;
          end else begin
            ptr <= ptr + 5'd1;
          end
        end
        default: begin
          state <= IDLE;
          ptr   <= '0;
        end
      endcase
    end
  end

  // Reset loads zero rather than CLR_VAL; a hardwired register 0 is never loaded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      for (int k = 0; k < 32; k++) begin
        if (!(ZERO_REG && k == 0)) begin
          if (clr_hit[k]) begin
            regs[k] <= CLR_VAL;
          end else if (wr_hit[k]) begin
            regs[k] <= wr.wd;
          end
        end
      end
    end
  end

  assign wr.wr_ack = wr_ack_q;
  assign wr.busy   = (state == CLEAR);

  assign q0  = ZERO_REG ? '0 : regs[0];
  assign q1  = regs[1];
  assign q2  = regs[2];
  assign q3  = regs[3];
  assign q4  = regs[4];
  assign q5  = regs[5];
  assign q6  = regs[6];
  assign q7  = regs[7];
  assign q8  = regs[8];
  assign q9  = regs[9];
  assign q10 = regs[10];
  assign q11 = regs[11];
  assign q12 = regs[12];
  assign q13 = regs[13];
  assign q14 = regs[14];
  assign q15 = regs[15];
  assign q16 = regs[16];
  assign q17 = regs[17];
  assign q18 = regs[18];
  assign q19 = regs[19];
  assign q20 = regs[20];
  assign q21 = regs[21];
  assign q22 = regs[22];
  assign q23 = regs[23];
  assign q24 = regs[24];
  assign q25 = regs[25];
  assign q26 = regs[26];
  assign q27 = regs[27];
  assign q28 = regs[28];
  assign q29 = regs[29];
  assign q30 = regs[30];
  assign q31 = regs[31];

endmodule
